reg_writeback: RTL and testbench

Owns the register-file write port (RDaddr/RDdata/RegWrite) and merges two result sources into it. The sources are the in-order pipeline WB stage and long-latency producers such as the multi-cycle divider and the late-load return. Late results are buffered in a small FIFO and drained into free writeback slots. Starvation is prevented by a stall request to the pipeline, and a pending-write query serves decode-stage hazard detection.

---
 rtl/reg_writeback.sv | 153 +++++++++++++++
 tb/tb_reg_writeback.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// Register-file write-port owner: merges in-order WB results with buffered late results
// (divider, late loads), with an anti-starvation stall and a pending-write hazard query.
module reg_writeback #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              WBvalid_i,
  input  logic [ADDR_W-1:0] WBaddr_i,
  input  logic [DATA_W-1:0] WBdata_i,
  input  logic              Lvalid_i,
  output logic              Lready_o,
  input  logic [ADDR_W-1:0] Laddr_i,
  input  logic [DATA_W-1:0] Ldata_i,
  input  logic [ADDR_W-1:0] Qaddr_i,
  output logic              Qpend_o,
  output logic              stall_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] RDaddr_o,
  output logic [DATA_W-1:0] RDdata_o,
  output logic              RegWrite_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  // Late-result storage; head is read combinationally so it can win arbitration the
  // cycle after it is enqueued.
  logic [ADDR_W-1:0] r_addr_mem [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];

  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [STV_W-1:0]  r_starve;
  logic              r_stall;
  logic              r_err;
  logic              r_reg_write;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_rd_data;

  logic              w_empty;
  logic              w_lready;
  logic              w_wb_ok;
  logic              w_grant_head;
  logic              w_grant_wb;
  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_count_next;
  logic [STV_W-1:0]  w_starve_next;
  logic              w_stall_next;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic [DEPTH-1:0]  w_hit;

  assign w_empty  = (r_count == '0);
  assign w_lready = (r_count < CNT_W'(DEPTH));
  assign w_wb_ok  = WBvalid_i && (WBaddr_i != '0);

  // A stall cycle always belongs to the FIFO head; otherwise the pipeline has priority.
  assign w_grant_head = !w_empty && (r_stall || !w_wb_ok);
  assign w_grant_wb   = !r_stall && w_wb_ok;

  // Writes to r0 are accepted on the handshake but never stored.
  assign w_push = Lvalid_i && w_lready && (Laddr_i != '0);
  assign w_pop  = w_grant_head;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_comb begin
    w_starve_next = '0;
    if (!w_empty && !w_grant_head) begin
      w_starve_next = r_starve + STV_W'(1);
    end
  end

  assign w_stall_next = (w_starve_next == STV_W'(STARVE_MAX));

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = r_rd_addr;
    w_wr_data = r_rd_data;
    if (w_grant_head) begin
      w_wr_en   = 1'b1;
      w_wr_addr = r_addr_mem[r_rd_ptr];
      w_wr_data = r_data_mem[r_rd_ptr];
    end else if (w_grant_wb) begin
      w_wr_en   = 1'b1;
      w_wr_addr = WBaddr_i;
      w_wr_data = WBdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_addr_mem[r_wr_ptr] <= Laddr_i;
      r_data_mem[r_wr_ptr] <= Ldata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_starve    <= '0;
      r_stall     <= 1'b0;
      r_err       <= 1'b0;
      r_reg_write <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_data   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count     <= w_count_next;
      r_starve    <= w_starve_next;
      r_stall     <= w_stall_next;
      // Pipeline asserting a write during a requested bubble is a contract violation.
      if (r_stall && WBvalid_i) r_err <= 1'b1;
      r_reg_write <= w_wr_en;
      r_rd_addr   <= w_wr_addr;
      r_rd_data   <= w_wr_data;
    end
  end

  // Hazard query: slot gi is live when its distance from the read pointer is below count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_qpend
    logic [PTR_W-1:0] w_off;
    assign w_off     = PTR_W'(gi) - r_rd_ptr;
    assign w_hit[gi] = ({1'b0, w_off} < r_count) && (r_addr_mem[gi] == Qaddr_i);
  end

  assign Qpend_o    = (|w_hit) && (Qaddr_i != '0);
  assign Lready_o   = w_lready;
  assign stall_o    = r_stall;
  assign err_o      = r_err;
  assign RegWrite_o = r_reg_write;
  assign RDaddr_o   = r_rd_addr;
  assign RDdata_o   = r_rd_data;

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: queue-based reference model, directed scenarios
// with literal expectations, and randomized traffic including an asynchronous reset.
module tb_reg_writeback;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;
  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 32;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic              WBvalid_i;
  logic [ADDR_W-1:0] WBaddr_i;
  logic [DATA_W-1:0] WBdata_i;
  logic              Lvalid_i;
  logic              Lready_o;
  logic [ADDR_W-1:0] Laddr_i;
  logic [DATA_W-1:0] Ldata_i;
  logic [ADDR_W-1:0] Qaddr_i;
  logic              Qpend_o;
  logic              stall_o;
  logic              err_o;
  logic [ADDR_W-1:0] RDaddr_o;
  logic [DATA_W-1:0] RDdata_o;
  logic              RegWrite_o;

  reg_writeback #(
    .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .WBvalid_i(WBvalid_i), .WBaddr_i(WBaddr_i), .WBdata_i(WBdata_i),
    .Lvalid_i(Lvalid_i), .Lready_o(Lready_o), .Laddr_i(Laddr_i), .Ldata_i(Ldata_i),
    .Qaddr_i(Qaddr_i), .Qpend_o(Qpend_o), .stall_o(stall_o), .err_o(err_o),
    .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o), .RegWrite_o(RegWrite_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  // Reference model state
  ent_t              mq[$];
  int                m_starve;
  bit                m_stall;
  bit                m_err;
  bit                e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_data;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_stall  = 1'b0;
    m_err    = 1'b0;
    e_we     = 1'b0;
    e_addr   = '0;
    e_data   = '0;
  endtask

  // One clock edge of the specified behaviour, evaluated from the current inputs.
  task automatic model_step();
    bit   nonempty;
    bit   lready;
    bit   head_g;
    bit   pipe_g;
    ent_t e;
    nonempty = (mq.size() > 0);
    lready   = (mq.size() < DEPTH);
    head_g   = 1'b0;
    pipe_g   = 1'b0;
    if (m_stall) begin
      head_g = nonempty;
      if (WBvalid_i) m_err = 1'b1;
    end else if (WBvalid_i && WBaddr_i != 0) begin
      pipe_g = 1'b1;
    end else if (nonempty) begin
      head_g = 1'b1;
    end
    e_we = head_g || pipe_g;
    if (head_g) begin
      e = mq.pop_front();
      e_addr = e.a;
      e_data = e.d;
    end else if (pipe_g) begin
      e_addr = WBaddr_i;
      e_data = WBdata_i;
    end
    if (Lvalid_i && lready && Laddr_i != 0) begin
      e.a = Laddr_i;
      e.d = Ldata_i;
      mq.push_back(e);
    end
    if (nonempty && !head_g) m_starve++;
    else m_starve = 0;
    m_stall = (m_starve == STARVE_MAX);
  endtask

  function automatic bit model_qpend();
    bit q = 1'b0;
    foreach (mq[i]) if (mq[i].a == Qaddr_i) q = 1'b1;
    return q;
  endfunction

  // Inputs are driven at the falling edge before calling; outputs sampled mid-cycle.
  task automatic step();
    #1;
    chk("Lready", 64'(Lready_o), 64'(mq.size() < DEPTH));
    chk("Qpend", 64'(Qpend_o), 64'(model_qpend()));
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    chk("RegWrite", 64'(RegWrite_o), 64'(e_we));
    chk("stall", 64'(stall_o), 64'(m_stall));
    chk("err", 64'(err_o), 64'(m_err));
    if (e_we) begin
      chk("RDaddr", 64'(RDaddr_o), 64'(e_addr));
      chk("RDdata", 64'(RDdata_o), 64'(e_data));
      $display("wr r%0d <= %08h", e_addr, e_data);
    end
  endtask

  task automatic set_idle();
    WBvalid_i = 1'b0; WBaddr_i = '0; WBdata_i = '0;
    Lvalid_i  = 1'b0; Laddr_i  = '0; Ldata_i  = '0;
    Qaddr_i   = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (mq.size() != 0 || m_stall); i++) begin
      set_idle();
      step();
    end
    set_idle();
    step();
  endtask

  task automatic rand_phase(input int n, input bit allow_viol);
    for (int i = 0; i < n; i++) begin
      WBvalid_i = m_stall ? (allow_viol && $urandom_range(0, 39) == 0)
                          : ($urandom_range(0, 99) < 65);
      WBaddr_i  = ADDR_W'($urandom_range(0, 12));
      WBdata_i  = $urandom;
      Lvalid_i  = ($urandom_range(0, 99) < 50);
      Laddr_i   = ADDR_W'($urandom_range(0, 9));
      Ldata_i   = $urandom;
      Qaddr_i   = ADDR_W'($urandom_range(0, 9));
      step();
    end
  endtask

  initial begin
    int k;
    bit acc;
    set_idle();
    model_reset();
    rst_n_i = 1'b0;
    #1;
    chk("rst_RegWrite", 64'(RegWrite_o), 64'd0);
    chk("rst_RDaddr", 64'(RDaddr_o), 64'd0);
    chk("rst_RDdata", 64'(RDdata_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_Lready", 64'(Lready_o), 64'd1);
    @(negedge clk_i);
    #2 rst_n_i = 1'b1;

    // Pipeline write
    WBvalid_i = 1'b1; WBaddr_i = 5'd5; WBdata_i = 32'hDEADBEEF;
    step();
    chk("t1_we", 64'(RegWrite_o), 64'd1);
    chk("t1_addr", 64'(RDaddr_o), 64'd5);
    chk("t1_data", 64'(RDdata_o), 64'hDEADBEEF);
    set_idle();
    step();
    chk("t1_we_off", 64'(RegWrite_o), 64'd0);

    // Zero register from both sources
    for (int i = 0; i < 4; i++) begin
      WBvalid_i = 1'b1; WBaddr_i = '0; WBdata_i = 32'h1234;
      Lvalid_i  = 1'b1; Laddr_i  = '0; Ldata_i  = 32'h1234;
      step();
      chk("t2_we", 64'(RegWrite_o), 64'd0);
      chk("t2_lready", 64'(Lready_o), 64'd1);
    end
    drain();

    // Late drain r3,r4,r5
    set_idle(); Qaddr_i = 5'd4;
    Lvalid_i = 1'b1; Laddr_i = 5'd3; Ldata_i = 32'd1;
    step();
    chk("t3_we_a", 64'(RegWrite_o), 64'd0);
    Laddr_i = 5'd4; Ldata_i = 32'd2;
    step();
    chk("t3_addr_r3", 64'(RDaddr_o), 64'd3);
    chk("t3_data_r3", 64'(RDdata_o), 64'd1);
    Laddr_i = 5'd5; Ldata_i = 32'd3;
    #1 chk("t3_qpend_on", 64'(Qpend_o), 64'd1);
    step();
    chk("t3_addr_r4", 64'(RDaddr_o), 64'd4);
    chk("t3_data_r4", 64'(RDdata_o), 64'd2);
    Lvalid_i = 1'b0;
    #1 chk("t3_qpend_off", 64'(Qpend_o), 64'd0);
    step();
    chk("t3_we_r5", 64'(RegWrite_o), 64'd1);
    chk("t3_addr_r5", 64'(RDaddr_o), 64'd5);
    chk("t3_data_r5", 64'(RDdata_o), 64'd3);
    step();
    chk("t3_we_end", 64'(RegWrite_o), 64'd0);
    drain();

    // Full FIFO and starvation stall
    k = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      WBvalid_i = !m_stall; WBaddr_i = 5'd20; WBdata_i = $urandom;
      Lvalid_i  = (k < 5); Laddr_i = ADDR_W'(10 + k); Ldata_i = 32'hA0 + 32'(k);
      Qaddr_i   = 5'd10;
      acc = (k < 5) && (mq.size() < DEPTH);
      if (cyc == 5) chk("t4_lready_full", 64'(Lready_o), 64'd0);
      step();
      if (acc) k++;
      if (cyc == 8) chk("t4_stall_pre", 64'(stall_o), 64'd0);
      if (cyc == 9) chk("t4_stall", 64'(stall_o), 64'd1);
      if (cyc == 10) begin
        chk("t4_head_we", 64'(RegWrite_o), 64'd1);
        chk("t4_head_addr", 64'(RDaddr_o), 64'd10);
        chk("t4_head_data", 64'(RDdata_o), 64'hA0);
        chk("t4_stall_off", 64'(stall_o), 64'd0);
      end
    end
    drain();

    // Contract violation during stall
    for (int cyc = 1; cyc <= 13; cyc++) begin
      WBvalid_i = 1'b1; WBaddr_i = 5'd7; WBdata_i = 32'hBAD0BAD0;
      Lvalid_i  = (cyc == 1); Laddr_i = 5'd9; Ldata_i = 32'h99;
      Qaddr_i   = 5'd9;
      step();
      if (cyc == 10) begin
        chk("t5_addr", 64'(RDaddr_o), 64'd9);
        chk("t5_data", 64'(RDdata_o), 64'h99);
        chk("t5_err", 64'(err_o), 64'd1);
      end
    end
    chk("t5_err_hold", 64'(err_o), 64'd1);
    drain();

    rand_phase(1500, 1'b1);
    drain();

    // Asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      WBvalid_i = 1'b1; WBaddr_i = 5'd20; WBdata_i = $urandom;
      Lvalid_i  = 1'b1; Laddr_i = ADDR_W'(21 + i); Ldata_i = $urandom;
      Qaddr_i   = 5'd22;
      step();
    end
    set_idle(); Qaddr_i = 5'd22;
    #2 rst_n_i = 1'b0;
    #1;
    chk("t6_we", 64'(RegWrite_o), 64'd0);
    chk("t6_lready", 64'(Lready_o), 64'd1);
    chk("t6_qpend", 64'(Qpend_o), 64'd0);
    chk("t6_stall", 64'(stall_o), 64'd0);
    chk("t6_err", 64'(err_o), 64'd0);
    model_reset();
    @(negedge clk_i);
    #2 rst_n_i = 1'b1;
    drain();

    rand_phase(1500, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
